// File: rtl/fft_pkg.sv
// Shared constants, state encoding and butterfly address arithmetic for the
// radix-2 DIT FFT stage sequencer.
package fft_pkg;

    localparam int LOG2N = 5;
    localparam int N     = 2 ** LOG2N;
    localparam int STG_W = $clog2(LOG2N + 1);
    localparam int TW_W  = $clog2(N / 2);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [TW_W-1:0]  tw;
    } bfly_addr_t;

    // Butterfly k of stage s: group index k>>s, offset k&(half-1) within the group.
    function automatic bfly_addr_t bfly_addr(input logic [LOG2N-2:0] k,
                                             input logic [STG_W-1:0] s);
        bfly_addr_t       r;
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] half;
        logic [LOG2N-1:0] low;
        kk   = {1'b0, k};
        half = LOG2N'(1) << s;
        low  = kk & (half - LOG2N'(1));
        r.a  = ((kk >> s) << (s + STG_W'(1))) | low;
        r.b  = r.a + half;
        r.tw = TW_W'(low << (STG_W'(LOG2N - 1) - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake and memory-address bundle between the FFT stage sequencer and
// the host, butterfly memory, butterfly unit and twiddle ROM.
interface fft_seq_if
    import fft_pkg::*;
#(
    parameter int ADDR_SIZE      = LOG2N,
    parameter int TWID_ADDR_SIZE = ADDR_SIZE - 1,
    parameter int STAGE_W        = $clog2(ADDR_SIZE + 1)
);

    logic                      i_start;
    logic                      o_busy;
    logic                      o_done;
    logic [STAGE_W-1:0]        o_stage;
    logic                      o_rden;
    logic [ADDR_SIZE-1:0]      o_rdaddr_A;
    logic [ADDR_SIZE-1:0]      o_rdaddr_B;
    logic [TWID_ADDR_SIZE-1:0] o_rdaddr_tw;
    logic                      o_wren;
    logic [ADDR_SIZE-1:0]      o_wraddr_A;
    logic [ADDR_SIZE-1:0]      o_wraddr_B;

    modport master (
        input  i_start,
        output o_busy, o_done, o_stage,
        output o_rden, o_rdaddr_A, o_rdaddr_B, o_rdaddr_tw,
        output o_wren, o_wraddr_A, o_wraddr_B
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_stage,
        input  o_rden, o_rdaddr_A, o_rdaddr_B, o_rdaddr_tw,
        input  o_wren, o_wraddr_A, o_wraddr_B
    );

endinterface

// File: rtl/fft_stage_sequencer_addr_delay_line.sv
// Fixed-depth shift register that replays read addresses as write addresses
// once the butterfly datapath latency has elapsed.
module addr_delay_line #(
    parameter int ADDR_SIZE = 5,
    parameter int DEPTH     = 3
) (
    input  logic                 clk_sys,
    input  logic                 rst_b,
    input  logic                 valid_in,
    input  logic [ADDR_SIZE-1:0] a_in,
    input  logic [ADDR_SIZE-1:0] b_in,
    output logic                 valid_out,
    output logic [ADDR_SIZE-1:0] a_out,
    output logic [ADDR_SIZE-1:0] b_out
);

    typedef struct packed {
        logic                 v;
        logic [ADDR_SIZE-1:0] a;
        logic [ADDR_SIZE-1:0] b;
    } tap_t;

    tap_t taps [DEPTH];

    // Clearing on reset drops in-flight butterflies so no stale write follows.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= '{v: valid_in, a: a_in, b: b_in};
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign valid_out = taps[DEPTH-1].v;
    assign a_out     = taps[DEPTH-1].a;
    assign b_out     = taps[DEPTH-1].b;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Start/done controller walking every stage and butterfly of an in-place
// radix-2 DIT FFT, issuing read, twiddle and delayed write addresses.
//
// state | meaning
// IDLE  | waiting for i_start, outputs quiet
// READ  | one butterfly read per cycle, k = 0 .. N/2-1
// DRAIN | BFLY_LATENCY cycles letting the stage's writes land before next stage
// DONE  | one-cycle o_done pulse, then back to IDLE
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int ADDR_SIZE      = LOG2N,
    parameter int TWID_ADDR_SIZE = ADDR_SIZE - 1,
    parameter int BFLY_LATENCY   = 3
) (
    input  logic      i_CLK,
    input  logic      i_RST,
    fft_seq_if.master bus
);

    localparam int SW = $clog2(ADDR_SIZE + 1);
    localparam int KW = ADDR_SIZE - 1;
    localparam int DW = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(ADDR_SIZE - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(BFLY_LATENCY - 1);

    seq_state_t state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [SW-1:0] s, s_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    bfly_addr_t    addr_nx;

    logic                      rden;
    logic                      busy;
    logic                      done;
    logic [ADDR_SIZE-1:0]      ra;
    logic [ADDR_SIZE-1:0]      rb;
    logic [TWID_ADDR_SIZE-1:0] rtw;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        s_nx     = s;
        dcnt_nx  = dcnt;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nx = READ;
                    k_nx     = '0;
                    s_nx     = '0;
                end
            end
            READ: begin
                if (k == K_LAST) begin
                    state_nx = DRAIN;
                    k_nx     = '0;
                    dcnt_nx  = D_LOAD;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == '0) begin
                    if (s == S_LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = READ;
                        s_nx     = s + 1'b1;
                    end
                end else begin
                    dcnt_nx = dcnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                s_nx     = '0;
            end
            default: state_nx = IDLE;
        endcase
        // Addresses are computed for the upcoming cycle so they register alongside o_rden.
        addr_nx = bfly_addr(k_nx, s_nx);
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            dcnt  <= '0;
            rden  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            rtw   <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            s     <= s_nx;
            dcnt  <= dcnt_nx;
            rden  <= (state_nx == READ);
            busy  <= (state_nx == READ) || (state_nx == DRAIN);
            done  <= (state_nx == DONE);
            if (state_nx == READ) begin
                ra  <= addr_nx.a;
                rb  <= addr_nx.b;
                rtw <= addr_nx.tw;
            end
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_stage     = s;
    assign bus.o_rden      = rden;
    assign bus.o_rdaddr_A  = ra;
    assign bus.o_rdaddr_B  = rb;
    assign bus.o_rdaddr_tw = rtw;

    addr_delay_line #(
        .ADDR_SIZE (ADDR_SIZE),
        .DEPTH     (BFLY_LATENCY)
    ) u_dly (
        .clk_sys   (i_CLK),
        .rst_b     (i_RST),
        .valid_in  (rden),
        .a_in      (ra),
        .b_in      (rb),
        .valid_out (bus.o_wren),
        .a_out     (bus.o_wraddr_A),
        .b_out     (bus.o_wraddr_B)
    );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: expected reads, writes and done
// pulses are queued at start time and popped by an independent monitor.
module tb_fft_stage_sequencer;

    localparam int AW        = 5;
    localparam int TWW       = 4;
    localparam int LAT       = 3;
    localparam int NPTS      = 32;
    localparam int NSTG      = 5;
    localparam int STAGE_CYC = NPTS / 2 + LAT;

    logic i_CLK = 1'b0;
    logic i_RST = 1'b0;

    fft_seq_if #(.ADDR_SIZE(AW), .TWID_ADDR_SIZE(TWW)) bus ();

    fft_stage_sequencer #(
        .ADDR_SIZE      (AW),
        .TWID_ADDR_SIZE (TWW),
        .BFLY_LATENCY   (LAT)
    ) dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        int unsigned cyc;
        int unsigned a;
        int unsigned b;
        int unsigned tw;
        int unsigned stage;
    } rd_exp_t;

    typedef struct {
        int unsigned cyc;
        int unsigned a;
        int unsigned b;
    } wr_exp_t;

    rd_exp_t     rq[$];
    wr_exp_t     wq[$];
    int unsigned dq[$];

    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned n_done   = 0;
    int unsigned cyc      = 0;
    int unsigned zero_cnt = 0;
    int unsigned bf       = 0;
    int unsigned bt       = 0;
    bit          active   = 1'b0;
    bit          pend [NPTS];

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: stage s pairs elements span=2^s apart; groups of 2*span walked in order,
    // twiddle index = offset * (N / (2*span)).
    function automatic void push_transform(input int unsigned p);
        int unsigned k;
        for (int s = 0; s < NSTG; s++) begin
            int unsigned span = 1 << s;
            k = 0;
            for (int j = 0; j < NPTS / (2 * span); j++) begin
                for (int i = 0; i < span; i++) begin
                    int unsigned a  = j * 2 * span + i;
                    int unsigned t  = p + s * STAGE_CYC + k;
                    rq.push_back('{t, a, a + span, i * (NPTS / 2 / span), s});
                    wq.push_back('{t + LAT, a, a + span});
                    k++;
                end
            end
        end
        dq.push_back(p + NSTG * STAGE_CYC);
        bf     = p;
        bt     = p + NSTG * STAGE_CYC - 1;
        active = 1'b1;
    endfunction

    // Monitor
    rd_exp_t re;
    wr_exp_t we;
    int unsigned de;
    always @(negedge i_CLK) begin
        if (zero_cnt > 0) begin
            check("zero_outputs", {bus.o_busy, bus.o_done, bus.o_stage, bus.o_rden,
                                   bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_rdaddr_tw,
                                   bus.o_wren, bus.o_wraddr_A, bus.o_wraddr_B}, 64'd0);
            zero_cnt--;
        end
        check("busy", bus.o_busy, active && cyc >= bf && cyc <= bt);

        if (bus.o_done) begin
            n_done++;
            if (dq.size() == 0) check("done_unexpected", 1, 0);
            else begin
                de = dq.pop_front();
                check("done_cycle", cyc, de);
            end
        end else if (dq.size() != 0 && dq[0] == cyc) begin
            check("done_missing", 0, 1);
        end

        if (bus.o_rden) begin
            check("raw_hazard", {pend[bus.o_rdaddr_A], pend[bus.o_rdaddr_B]}, 0);
            if (rq.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                re = rq.pop_front();
                check("rd cyc/A/B/tw/stage",
                      {16'(cyc), 8'(bus.o_rdaddr_A), 8'(bus.o_rdaddr_B),
                       8'(bus.o_rdaddr_tw), 8'(bus.o_stage)},
                      {16'(re.cyc), 8'(re.a), 8'(re.b), 8'(re.tw), 8'(re.stage)});
            end
        end else if (rq.size() != 0 && rq[0].cyc == cyc) begin
            check("rd_missing", 0, 1);
        end

        if (bus.o_wren) begin
            if (wq.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                we = wq.pop_front();
                check("wr cyc/A/B",
                      {16'(cyc), 8'(bus.o_wraddr_A), 8'(bus.o_wraddr_B)},
                      {16'(we.cyc), 8'(we.a), 8'(we.b)});
            end
            pend[bus.o_wraddr_A] = 1'b0;
            pend[bus.o_wraddr_B] = 1'b0;
        end else if (wq.size() != 0 && wq[0].cyc == cyc) begin
            check("wr_missing", 0, 1);
        end

        if (bus.o_rden) begin
            pend[bus.o_rdaddr_A] = 1'b1;
            pend[bus.o_rdaddr_B] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic start_tf(output int unsigned p);
        p           = cyc + 1;
        bus.i_start = 1'b1;
        push_transform(p);
        tick();
        bus.i_start = 1'b0;
    endtask

    // Advance to relative cycle r of a transform whose first read is at cycle p.
    task automatic goto_r(input int unsigned p, input int unsigned r);
        while (cyc < p - 1 + r) tick();
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic reset_at(input int unsigned p, input int unsigned r);
        goto_r(p, r);
        i_RST = 1'b0;
        tick();
        rq.delete();
        wq.delete();
        dq.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        active   = 1'b0;
        zero_cnt = 1;
        i_RST    = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rq.size() + wq.size() + dq.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        check("queues_empty", rq.size() + wq.size() + dq.size(), 0);
    endtask

    int unsigned p;

    initial begin
        bus.i_start = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;
        zero_cnt = 12;
        tick();
        tick();
        i_RST = 1'b1;
        repeat (10) tick();

        // Directed transform with start pulses while busy and in the DONE cycle
        start_tf(p);
        goto_r(p, 40);
        pulse_start();
        goto_r(p, 96);
        pulse_start();
        wait_drain();
        check("transform_count", n_done, 1);

        // Reset mid-transform at cycle 50, then a full rerun
        repeat ($urandom_range(1, 6)) tick();
        start_tf(p);
        reset_at(p, 50);
        repeat ($urandom_range(1, 6)) tick();
        start_tf(p);
        while (cyc <= p + 95) begin
            bus.i_start = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.i_start = 1'b0;
        wait_drain();

        // Reset at a random point, then a clean transform
        repeat ($urandom_range(1, 6)) tick();
        start_tf(p);
        reset_at(p, $urandom_range(2, 94));
        repeat ($urandom_range(1, 6)) tick();
        start_tf(p);
        wait_drain();
        repeat (4) tick();
        check("done_total", n_done, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Top-level controller for the in-place radix-2 DIT FFT pipeline. On a start strobe it walks every stage and butterfly of an N-point transform. For each butterfly it issues the dual-port read addresses (A, B) and the twiddle ROM address. It replays the same A/B addresses as write addresses once the butterfly datapath latency has elapsed. It sits between the host/control logic and the butterfly memory, butterfly unit and twiddle ROM, and replaces free-running address walking with a start/done handshake.

Parameters:
ADDR_SIZE, 5, log2 of transform length N (N = 32 points, L = ADDR_SIZE stages)
TWID_ADDR_SIZE, ADDR_SIZE-1, twiddle ROM address width (N/2 entries)
BFLY_LATENCY, 3, cycles from o_rden/read address to matching o_wren/write address (>= 1)

Ports:
i_CLK  in  1  clock, all logic on rising edge
i_RST  in  1  reset, synchronous, active-low
i_start  in  1  start transform; sampled only in IDLE
o_busy  out  1  high from first READ cycle through last write
o_done  out  1  single-cycle pulse after final write
o_stage  out  $clog2(ADDR_SIZE+1)  current stage index s
o_rden  out  1  read enable for butterfly memory and twiddle ROM
o_rdaddr_A  out  ADDR_SIZE  butterfly top-input read address
o_rdaddr_B  out  ADDR_SIZE  butterfly bottom-input read address
o_rdaddr_tw  out  TWID_ADDR_SIZE  twiddle ROM address
o_wren  out  1  write enable for butterfly results
o_wraddr_A  out  ADDR_SIZE  write address, top output
o_wraddr_B  out  ADDR_SIZE  write address, bottom output

Behaviour:
- Reset (i_RST==0 at an edge): state=IDLE. All outputs 0. Butterfly counter k=0, stage s=0. Delay-line valid bits cleared. Applies mid-transform too: in-flight writes are discarded and no o_wren follows reset.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: i_start=1 -> READ with s=0, k=0. i_start is ignored in all other states.
- READ: one butterfly per cycle. o_rden=1.
  - half = 2^s
  - o_rdaddr_A = ((k>>s)<<(s+1)) | (k & (half-1))
  - o_rdaddr_B = o_rdaddr_A + half
  - o_rdaddr_tw = (k & (half-1)) << (L-1-s)
  - All outputs are registered and valid in the same cycle as o_rden.
  - k = N/2-1 -> DRAIN with k=0. Otherwise k += 1.
- DRAIN: o_rden=0, read addresses hold at their last values. Lasts exactly BFLY_LATENCY cycles so stage s+1 never reads a location still pending write (no RAW hazard). Exit goes to READ with s+1, or to DONE if s==L-1.
- Write path: the delay line shifts {valid, A, B} every cycle. o_wren/o_wraddr_A/o_wraddr_B equal the o_rden/o_rdaddr_A/o_rdaddr_B values from BFLY_LATENCY cycles earlier. o_wren may overlap READ only within the same stage.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. i_start in that cycle is ignored.
- o_busy=1 in READ and DRAIN.
- Timing: each stage is N/2 + BFLY_LATENCY cycles. Total is L*(N/2+BFLY_LATENCY) busy cycles, which is 95 for the defaults.
- Width rules:
  - Address arithmetic is unsigned, ADDR_SIZE bits, no wrap is possible by construction.
  - Twiddle shift is truncated to TWID_ADDR_SIZE.
  - o_stage saturates at L-1 while busy and returns to 0 in IDLE.

Decomposition:
- Shared package fft_pkg:
  - ADDR_SIZE/LOG2N and N constants
  - state enum {IDLE, READ, DRAIN, DONE}
  - pure function bfly_addr(k, s) returning {A, B, tw}, reused by the testbench model
- One sub-module: addr_delay_line, a parameterised BFLY_LATENCY-deep shift register of {valid, A, B} with synchronous active-low clear.

Test Plan:
- Reset then idle: hold i_RST=0 for 2 cycles, i_start=0 -> all outputs 0, o_busy=0 for 10 cycles.
- Start at cycle 0 (defaults) -> stage 0 reads cycles 1..16: cycle 1 A=0 B=1 tw=0, cycle 2 A=2 B=3 tw=0. First o_wren at cycle 4 with wraddr A=0 B=1.
- Stage 1 and stage 4 addressing:
  - Stage 1 starts at cycle 20: k=1 gives A=1 B=3 tw=8, k=2 gives A=4 B=6 tw=0.
  - Stage 4 (cycles 77..92): A=k, B=k+16, tw=k.
- Completion: last o_wren at cycle 95 with A=15 B=31. o_done high only at cycle 96, o_busy low from 96. No read from stage s+1 ever precedes the last write of stage s (scoreboard check).
- i_start pulsed during busy (cycle 40) and in the DONE cycle -> ignored. Transform count stays 1 and the address sequence is unchanged.
- Reset mid-operation: assert i_RST=0 at cycle 50 for 1 cycle -> next cycle all outputs 0, no o_wren for in-flight reads. A new i_start reproduces the full 95-cycle sequence from A=0 B=1.
